// File: rtl/sd_save_key_filter.sv
// Debounces the active-low save push-button into a one-cycle save request.
// Presses that arrive while a save is busy or within the re-trigger holdoff are reported as dropped.
//
// state     | meaning
// IDLE      | key released and stable
// PRESS_CHK | key_s seen pressed, counting stable pressed samples
// PRESSED   | press confirmed, key held
// REL_CHK   | key_s seen released, counting stable released samples
module sd_save_key_filter #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int HOLDOFF_CYCLES  = 50_000_000
) (
  input  logic i_ddr_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  input  logic i_save_busy,
  output logic o_sd_save_key,
  output logic o_key_level,
  output logic o_req_dropped
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              save_q, save_d;
  logic              drop_q, drop_d;
  logic              level_q, level_d;
  logic              key_s;
  logic              press_evt;

  assign key_s = ~sync2_q;

  always_comb begin
    sync1_d   = i_key_n;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    save_d    = 1'b0;
    drop_d    = 1'b0;
    press_evt = 1'b0;
    hold_d    = (hold_q != '0) ? hold_q - HOLD_W'(1) : '0;

    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!key_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_d = REL_CHK;
          cnt_d   = '0;
        end
      end
      REL_CHK: begin
        if (key_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Busy and holdoff are judged on the pre-update hold value; a load beats the decrement.
    if (press_evt) begin
      if ((hold_q == '0) && !i_save_busy) begin
        save_d = 1'b1;
        hold_d = HOLD_LOAD;
      end else begin
        drop_d = 1'b1;
      end
    end

    level_d = (state_d == PRESSED) || (state_d == REL_CHK);
  end

  always_ff @(posedge i_ddr_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      save_q  <= 1'b0;
      drop_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      save_q  <= save_d;
      drop_q  <= drop_d;
      level_q <= level_d;
    end
  end

  assign o_sd_save_key = save_q;
  assign o_req_dropped = drop_q;
  assign o_key_level   = level_q;

endmodule

// File: tb/tb_sd_save_key_filter.sv
// Bench for sd_save_key_filter: two instances (short and long holdoff) driven in parallel,
// compared every cycle against a run-length/time-stamp reference model.
module tb_sd_save_key_filter;

  localparam int DEB    = 8;
  localparam int HOLD_A = 16;
  localparam int HOLD_B = 40;

  logic clk = 1'b0;
  logic i_rst_n, i_key_n, i_save_busy;
  logic so_a, lv_a, dr_a, so_b, lv_b, dr_b;

  always #5 clk = ~clk;

  sd_save_key_filter #(.DEBOUNCE_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD_A)) u_dut_a (
    .i_ddr_clk(clk), .i_rst_n(i_rst_n), .i_key_n(i_key_n), .i_save_busy(i_save_busy),
    .o_sd_save_key(so_a), .o_key_level(lv_a), .o_req_dropped(dr_a)
  );

  sd_save_key_filter #(.DEBOUNCE_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD_B)) u_dut_b (
    .i_ddr_clk(clk), .i_rst_n(i_rst_n), .i_key_n(i_key_n), .i_save_busy(i_save_busy),
    .o_sd_save_key(so_b), .o_key_level(lv_b), .o_req_dropped(dr_b)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_edge  = 0;

  // Reference model: raw samples reach the filter two edges late; the level flips once
  // DEB+1 consecutive samples disagree with it; a press is issued if not busy and more
  // than H edges have passed since the last issued request.
  bit raw_q[$];
  bit m_level;
  int run;
  int last_iss[2];
  bit e_pulse[2];
  bit e_drop[2];
  int pa, pb, da, db;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp_v, n_edge);
  endtask

  task automatic model_reset();
    raw_q = {};
    raw_q.push_back(1'b1);
    raw_q.push_back(1'b1);
    m_level = 1'b0;
    run = 0;
    for (int k = 0; k < 2; k++) begin
      last_iss[k] = n_edge - 1000;
      e_pulse[k]  = 1'b0;
      e_drop[k]   = 1'b0;
    end
  endtask

  task automatic clr_seg();
    pa = 0; pb = 0; da = 0; db = 0;
  endtask

  task automatic step(input logic key, input logic busy);
    bit ks;
    int hk;
    i_key_n = key;
    i_save_busy = busy;
    @(posedge clk);
    n_edge++;
    ks = ~raw_q.pop_front();
    raw_q.push_back(key);
    for (int k = 0; k < 2; k++) begin
      e_pulse[k] = 1'b0;
      e_drop[k]  = 1'b0;
    end
    if (ks != m_level) begin
      run++;
      if (run == DEB + 1) begin
        m_level = ks;
        run = 0;
        if (ks) begin
          for (int k = 0; k < 2; k++) begin
            hk = (k == 0) ? HOLD_A : HOLD_B;
            if (!busy && (n_edge - last_iss[k] > hk)) begin
              e_pulse[k]  = 1'b1;
              last_iss[k] = n_edge;
            end else begin
              e_drop[k] = 1'b1;
            end
          end
        end
      end
    end else begin
      run = 0;
    end
    #1;
    chk("level_a", lv_a, m_level);
    chk("save_a",  so_a, e_pulse[0]);
    chk("drop_a",  dr_a, e_drop[0]);
    chk("level_b", lv_b, m_level);
    chk("save_b",  so_b, e_pulse[1]);
    chk("drop_b",  dr_b, e_drop[1]);
    pa += int'(so_a); pb += int'(so_b);
    da += int'(dr_a); db += int'(dr_b);
  endtask

  task automatic steps(input int n, input logic key, input logic busy);
    for (int i = 0; i < n; i++) step(key, busy);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_save_a"},  so_a, 0);
    chk({tag, "_level_a"}, lv_a, 0);
    chk({tag, "_drop_a"},  dr_a, 0);
    chk({tag, "_save_b"},  so_b, 0);
    chk({tag, "_level_b"}, lv_b, 0);
    chk({tag, "_drop_b"},  dr_b, 0);
  endtask

  task automatic do_reset(input int cycles);
    i_rst_n = 1'b0;
    #2;
    chk_zero("rst");
    repeat (cycles) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int blen;
    i_rst_n = 1'b0;
    i_key_n = 1'b1;
    i_save_busy = 1'b0;
    model_reset();
    #3;
    chk_zero("por");
    repeat (2) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
    steps(5, 1'b1, 1'b0);

    // 1: clean press
    clr_seg();
    steps(40, 1'b0, 1'b0);
    steps(50, 1'b1, 1'b0);
    chk("t1_pulses_a", pa, 1);
    chk("t1_pulses_b", pb, 1);

    // 2: bounce then held
    clr_seg();
    for (int i = 0; i < 30; i++) step(((i / 3) % 2) != 0, 1'b0);
    steps(30, 1'b0, 1'b0);
    steps(50, 1'b1, 1'b0);
    chk("t2_pulses_a", pa, 1);
    chk("t2_pulses_b", pb, 1);

    // 3: busy at confirmation
    clr_seg();
    steps(30, 1'b0, 1'b1);
    steps(50, 1'b1, 1'b0);
    chk("t3_pulses_a", pa, 0);
    chk("t3_drops_a",  da, 1);
    chk("t3_drops_b",  db, 1);

    // 4: presses confirmed 20 cycles apart; long-holdoff instance must drop the second
    clr_seg();
    steps(10, 1'b0, 1'b0);
    steps(10, 1'b1, 1'b0);
    steps(30, 1'b0, 1'b0);
    steps(50, 1'b1, 1'b0);
    chk("t4_pulses_a", pa, 2);
    chk("t4_pulses_b", pb, 1);
    chk("t4_drops_b",  db, 1);

    // 5: reset in PRESS_CHK (cnt=5) and again while pressed, key held throughout
    clr_seg();
    steps(8, 1'b0, 1'b0);
    do_reset(3);
    steps(20, 1'b0, 1'b0);
    do_reset(2);
    steps(20, 1'b0, 1'b0);
    steps(50, 1'b1, 1'b0);
    chk("t5_pulses_a", pa, 2);
    chk("t5_pulses_b", pb, 2);

    // 6: long hold with short release bounces
    clr_seg();
    blen = 0;
    for (int i = 0; i < 1000; i++) begin
      if (blen > 0) begin
        step(1'b1, 1'b0);
        blen--;
      end else begin
        step(1'b0, 1'b0);
        if (i > 20 && $urandom_range(0, 29) == 0) blen = $urandom_range(1, 7);
      end
    end
    steps(50, 1'b1, 1'b0);
    chk("t6_pulses_a", pa, 1);
    chk("t6_pulses_b", pb, 1);

    // randomized presses, releases, bounces and busy
    for (int s = 0; s < 60; s++) begin
      int plen, rlen;
      plen = $urandom_range(1, 30);
      rlen = $urandom_range(1, 40);
      for (int i = 0; i < plen; i++)
        step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
      for (int i = 0; i < rlen; i++)
        step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0));
    end
    steps(30, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
